// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit between execute stage and a multi-cycle data memory port
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned accesses instead of force-aligning them)
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  // Counter only needs to reach TIMEOUT_CYCLES-1; the terminal value is checked, not overflowed
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] timeout_cnt;
  logic [2:0]    cap_func3;
  logic [1:0]    cap_lane;

  logic          req_trap;
  logic [3:0]    req_be;
  logic [31:0]   req_wlane;
  logic [1:0]    load_shamt;
  logic [31:0]   load_shifted;
  logic [31:0]   load_data;

  // Decode incoming request: legality, optional misalignment trap, store byte enables and lane data
  always_comb begin
    req_trap  = 1'b1;
    req_be    = 4'b1111;
    req_wlane = req_wdata;
    if (req_write) begin
      req_trap = (req_func3 > 3'b010);
    end else begin
      req_trap = (req_func3 == 3'b011) || (req_func3 == 3'b110) || (req_func3 == 3'b111);
    end
`ifdef MISALIGN_TRAP_EN
    if ((req_func3[1:0] == 2'b01 && req_addr[0]) ||
        (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
      req_trap = 1'b1;
    end
`endif
    case (req_func3[1:0])
      2'b00: begin
        req_wlane = {4{req_wdata[7:0]}};
        if (req_write) req_be = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        req_wlane = {2{req_wdata[15:0]}};
        if (req_write) req_be = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        req_wlane = req_wdata;
        req_be    = 4'b1111;
      end
    endcase
  end

  // Select the addressed lane of the returned word and extend it to 32 bits
  always_comb begin
    load_shamt = 2'b00;
    case (cap_func3[1:0])
      2'b00:   load_shamt = cap_lane;
      2'b01:   load_shamt = {cap_lane[1], 1'b0};
      default: load_shamt = 2'b00;
    endcase
    load_shifted = mem_rdata >> {load_shamt, 3'b000};
    case (cap_func3)
      3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_data = {24'd0, load_shifted[7:0]};
      3'b101:  load_data = {16'd0, load_shifted[15:0]};
      default: load_data = load_shifted;
    endcase
  end

  // Transaction FSM with all outputs registered; memory signals held stable for the whole ACCESS phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timeout_cnt <= '0;
      cap_func3   <= 3'b000;
      cap_lane    <= 2'b00;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_err    <= 1'b0;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 30'd0;
      mem_wdata   <= 32'd0;
      mem_be      <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_func3 <= req_func3;
            cap_lane  <= req_addr[1:0];
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_trap) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state     <= S_ACCESS;
              mem_req   <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= req_addr[31:2];
              mem_be    <= req_be;
              mem_wdata <= req_write ? req_wlane : 32'd0;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack || (TIMEOUT_CYCLES != 0 && timeout_cnt == TO_LAST)) begin
            state       <= S_RESP;
            resp_valid  <= 1'b1;
            resp_err    <= !mem_ack;
            resp_rdata  <= (mem_ack && !mem_we) ? load_data : 32'd0;
            timeout_cnt <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 30'd0;
            mem_wdata   <= 32'd0;
            mem_be      <= 4'b0000;
          end else if (TIMEOUT_CYCLES != 0) begin
            timeout_cnt <= timeout_cnt + CW'(1);
          end
        end
        S_RESP: begin
          state       <= S_IDLE;
          timeout_cnt <= '0;
          resp_valid  <= 1'b0;
          resp_err    <= 1'b0;
          resp_rdata  <= 32'd0;
          busy        <= 1'b0;
          req_ready   <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit (TIMEOUT_CYCLES=4)
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_func3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ack;
    int          acc;
    logic [29:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwd;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } dir_t;

  dir_t rows [0:10];

  // Drives one request at the current negedge, plays memory with the given ack delay (99 = never),
  // and returns what was observed. Leaves the bench at the negedge after the response cycle.
  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int ack_delay,
                         output int lat, output int acc, output logic err, output logic [31:0] rdata,
                         output logic [29:0] maddr, output logic [3:0] be, output logic [31:0] mwd,
                         output logic we, output logic stable, output logic extra);
    lat = 0; acc = 0; err = 1'b0; rdata = 32'd0; maddr = 30'd0; be = 4'd0; mwd = 32'd0;
    we = 1'b0; stable = 1'b1; extra = 1'b0;
    req_valid = 1'b1; req_write = wr; req_func3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_func3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int i = 1; i <= 20; i++) begin
      mem_ack = 1'b0;
      if (resp_valid) begin
        lat = i; err = resp_err; rdata = resp_rdata;
        break;
      end
      if (mem_req) begin
        if (acc == 0) begin
          maddr = mem_addr; be = mem_be; mwd = mem_wdata; we = mem_we;
        end else if (mem_addr !== maddr || mem_be !== be || mem_wdata !== mwd || mem_we !== we) begin
          stable = 1'b0;
        end
        acc++;
        if (acc - 1 == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = rd;
        end else begin
          mem_rdata = $urandom;
        end
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    @(negedge clk);
    extra = resp_valid;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    vectors++;
    if ({resp_valid, resp_err, busy, mem_req, mem_we} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 00000", {resp_valid, resp_err, busy, mem_req, mem_we});
    end
    vectors++;
    if ({resp_rdata, mem_addr, mem_wdata, mem_be} !== 98'd0) begin
      miscompares++; $display("FAIL reset_buses: got %h want 0", {resp_rdata, mem_addr, mem_wdata, mem_be});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int lat, acc;
    logic err, we, stable, extra;
    logic [31:0] rdata, mwd;
    logic [29:0] maddr;
    logic [3:0] be;
    //          wr    f3    addr          wd            rd            ack acc maddr       be       mwd           lat err   rdata
    rows[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        3,  4, 30'h40, 4'b1111, 32'hDEADBEEF, 5, 1'b0, 32'h0};
    rows[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'h80FF7F01, 0,  1, 30'h40, 4'b1111, 32'h0,        2, 1'b0, 32'hFFFFFF80};
    rows[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h80FF7F01, 1,  2, 30'h40, 4'b1111, 32'h0,        3, 1'b0, 32'h00000080};
    rows[3]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80FF7F01, 0,  1, 30'h40, 4'b1111, 32'h0,        2, 1'b0, 32'hFFFF80FF};
    rows[4]  = '{1'b1, 3'd0, 32'h201, 32'h000000AB, 32'h0,        1,  2, 30'h80, 4'b0010, 32'hABABABAB, 3, 1'b0, 32'h0};
    rows[5]  = '{1'b1, 3'd1, 32'h202, 32'h00001234, 32'h0,        2,  3, 30'h80, 4'b1100, 32'h12341234, 4, 1'b0, 32'h0};
`ifdef MISALIGN_TRAP_EN
    rows[6]  = '{1'b0, 3'd2, 32'h102, 32'h0,        32'h80FF7F01, 0,  0, 30'h0,  4'b0000, 32'h0,        1, 1'b1, 32'h0};
`else
    rows[6]  = '{1'b0, 3'd2, 32'h102, 32'h0,        32'h80FF7F01, 0,  1, 30'h40, 4'b1111, 32'h0,        2, 1'b0, 32'h80FF7F01};
`endif
    rows[7]  = '{1'b0, 3'd3, 32'h0,   32'h0,        32'h0,        0,  0, 30'h0,  4'b0000, 32'h0,        1, 1'b1, 32'h0};
    rows[8]  = '{1'b0, 3'd2, 32'h300, 32'h0,        32'h0,        99, 4, 30'hC0, 4'b1111, 32'h0,        5, 1'b1, 32'h0};
    rows[9]  = '{1'b0, 3'd2, 32'h300, 32'h0,        32'h12345678, 3,  4, 30'hC0, 4'b1111, 32'h0,        5, 1'b0, 32'h12345678};
    rows[10] = '{1'b1, 3'd4, 32'h10,  32'h55,       32'h0,        0,  0, 30'h0,  4'b0000, 32'h0,        1, 1'b1, 32'h0};
    for (int r = 0; r <= 10; r++) begin
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++; $display("FAIL dir%0d_ready: got %b want 1", r, req_ready);
      end
      run_txn(rows[r].wr, rows[r].f3, rows[r].addr, rows[r].wd, rows[r].rd, rows[r].ack,
              lat, acc, err, rdata, maddr, be, mwd, we, stable, extra);
      vectors++;
      if (acc !== rows[r].acc) begin
        miscompares++; $display("FAIL dir%0d_access_cycles: got %0d want %0d", r, acc, rows[r].acc);
      end
      if (rows[r].acc != 0) begin
        vectors++;
        if ({maddr, be, we, stable} !== {rows[r].maddr, rows[r].be, rows[r].wr, 1'b1}) begin
          miscompares++;
          $display("FAIL dir%0d_mem_port: got addr %h be %b we %b stable %b want addr %h be %b we %b stable 1",
                   r, maddr, be, we, stable, rows[r].maddr, rows[r].be, rows[r].wr);
        end
        if (rows[r].wr) begin
          vectors++;
          if (mwd !== rows[r].mwd) begin
            miscompares++; $display("FAIL dir%0d_mem_wdata: got %h want %h", r, mwd, rows[r].mwd);
          end
        end
      end
      vectors++;
      if ({lat, err, rdata, extra} !== {rows[r].lat, rows[r].err, rows[r].rdata, 1'b0}) begin
        miscompares++;
        $display("FAIL dir%0d_resp: got lat %0d err %b rdata %h extra %b want lat %0d err %b rdata %h extra 0",
                 r, lat, err, rdata, extra, rows[r].lat, rows[r].err, rows[r].rdata);
      end
    end
  endtask

  task automatic test_random;
    int lat, acc, ack, size, off, exp_lat, exp_acc;
    logic err, we, stable, extra, wr, legal, trap, tmo;
    logic [2:0] f3;
    logic [31:0] addr, wd, rd, rdata, mwd, eaddr, exp_wd, exp_rd;
    logic [29:0] maddr;
    logic [3:0] be, exp_be;
    longint mask, val;
    for (int n = 0; n < 80; n++) begin
      wr = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wd = $urandom; rd = $urandom;
      ack = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 3));
      // reference rules: access size in bytes, naturally aligned effective address, lane = offset in word
      size  = 1 << f3[1:0];
      legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      trap  = !legal;
`ifdef MISALIGN_TRAP_EN
      if (legal && (addr % size) != 0) trap = 1'b1;
`endif
      tmo    = !trap && ack == 99;
      eaddr  = addr & ~(32'(size) - 32'd1);
      off    = int'(eaddr % 4);
      exp_be = wr ? 4'(((1 << size) - 1) << off) : 4'hF;
      exp_wd = (size == 1) ? wd[7:0] * 32'h01010101 : (size == 2) ? wd[15:0] * 32'h00010001 : wd;
      mask   = (64'd1 << (8 * size)) - 1;
      val    = (longint'(rd) >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && ((val >> (8 * size - 1)) & 1) == 1) val = val | ~mask;
      exp_rd  = (wr || trap || tmo) ? 32'd0 : val[31:0];
      exp_lat = trap ? 1 : tmo ? 5 : ack + 2;
      exp_acc = trap ? 0 : tmo ? 4 : ack + 1;
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++; $display("FAIL rnd%0d_ready: got %b want 1", n, req_ready);
      end
      run_txn(wr, f3, addr, wd, rd, ack, lat, acc, err, rdata, maddr, be, mwd, we, stable, extra);
      vectors++;
      if (acc !== exp_acc) begin
        miscompares++; $display("FAIL rnd%0d_access_cycles: got %0d want %0d (wr %b f3 %0d addr %h)", n, acc, exp_acc, wr, f3, addr);
      end
      if (!trap) begin
        vectors++;
        if ({maddr, be, we, stable} !== {addr[31:2], exp_be, wr, 1'b1}) begin
          miscompares++;
          $display("FAIL rnd%0d_mem_port: got addr %h be %b we %b stable %b want addr %h be %b we %b stable 1",
                   n, maddr, be, we, stable, addr[31:2], exp_be, wr);
        end
        if (wr) begin
          vectors++;
          if (mwd !== exp_wd) begin
            miscompares++; $display("FAIL rnd%0d_mem_wdata: got %h want %h", n, mwd, exp_wd);
          end
        end
      end
      vectors++;
      if ({lat, err, rdata, extra} !== {exp_lat, trap || tmo, exp_rd, 1'b0}) begin
        miscompares++;
        $display("FAIL rnd%0d_resp: got lat %0d err %b rdata %h extra %b want lat %0d err %b rdata %h extra 0 (wr %b f3 %0d addr %h rd %h)",
                 n, lat, err, rdata, extra, exp_lat, trap || tmo, exp_rd, wr, f3, addr, rd);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  task automatic test_ack_outside;
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    mem_ack = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++; $display("FAIL idle_ack_ignored: got %0d disturbed cycles want 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int lat, acc;
    logic err, we, stable, extra;
    logic [31:0] rdata, mwd;
    logic [29:0] maddr;
    logic [3:0] be;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
        miscompares++; $display("FAIL b2b%0d_idle: got ready %b busy %b want ready 1 busy 0", k, req_ready, busy);
      end
      run_txn(1'b0, 3'd2, 32'h40 * k, 32'd0, 32'hA5A50000 + k, 0, lat, acc, err, rdata, maddr, be, mwd, we, stable, extra);
      vectors++;
      if ({lat, err, rdata} !== {32'd2, 1'b0, 32'hA5A50000 + k}) begin
        miscompares++; $display("FAIL b2b%0d_resp: got lat %0d err %b rdata %h want lat 2 err 0 rdata %h", k, lat, err, rdata, 32'hA5A50000 + k);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat, acc, bad;
    logic err, we, stable, extra;
    logic [31:0] rdata, mwd;
    logic [29:0] maddr;
    logic [3:0] be;
    req_valid = 1'b1; req_write = 1'b0; req_func3 = 3'd2; req_addr = 32'h500;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_access: got mem_req %b want 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_req, busy, req_ready, resp_valid} !== 4'b0010) begin
      miscompares++; $display("FAIL rstmid_immediate: got req/busy/ready/valid %b want 0010", {mem_req, busy, req_ready, resp_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1;
      @(negedge clk);
      if (resp_valid !== 1'b0 || mem_req !== 1'b0) bad++;
    end
    mem_ack = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++; $display("FAIL rstmid_no_resp: got %0d cycles with activity want 0", bad);
    end
    run_txn(1'b0, 3'd2, 32'h504, 32'd0, 32'hCAFEF00D, 1, lat, acc, err, rdata, maddr, be, mwd, we, stable, extra);
    vectors++;
    if ({lat, err, rdata, maddr} !== {32'd3, 1'b0, 32'hCAFEF00D, 30'h141}) begin
      miscompares++; $display("FAIL rstmid_after: got lat %0d err %b rdata %h addr %h want lat 3 err 0 rdata cafef00d addr 141", lat, err, rdata, maddr);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ack_outside();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
